// File: rtl/cpu7_csr_ctl_pkg.sv
// Shared encodings for the CSR port controller: op codes, FSM states and
// the architectural CSR addresses the controller is commonly exercised with.
package cpu7_csr_ctl_pkg;

  localparam int GRLEN_DEF   = 32;
  localparam int CSR_BIT_DEF = 14;

  typedef enum logic [1:0] {
    CSR_OP_RD   = 2'b00,
    CSR_OP_WR   = 2'b01,
    CSR_OP_XCHG = 2'b10
  } csr_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RD   = 2'b01,
    ST_WR   = 2'b10,
    ST_RESP = 2'b11
  } csr_st_e;

  localparam logic [CSR_BIT_DEF-1:0] LSOC1K_CSR_CRMD  = 14'h0;
  localparam logic [CSR_BIT_DEF-1:0] LSOC1K_CSR_EPC   = 14'h6;
  localparam logic [CSR_BIT_DEF-1:0] LSOC1K_CSR_EBASE = 14'hC;

  // The reserved encoding 2'b11 behaves as a plain read.
  function automatic csr_op_e norm_op(input logic [1:0] op);
    case (op)
      2'b01:   norm_op = CSR_OP_WR;
      2'b10:   norm_op = CSR_OP_XCHG;
      default: norm_op = CSR_OP_RD;
    endcase
  endfunction

endpackage

// File: rtl/cpu7_csr_xchg_merge.sv
// Masked merge for CSRXCHG: bits set in mask come from the new value,
// the rest keep the old CSR contents.
module cpu7_csr_xchg_merge #(
  parameter int GRLEN = 32
) (
  input  logic [GRLEN-1:0] old_val,
  input  logic [GRLEN-1:0] new_val,
  input  logic [GRLEN-1:0] mask,
  output logic [GRLEN-1:0] merged
);

  assign merged = (new_val & mask) | (old_val & ~mask);

endmodule

// File: rtl/cpu7_csr_ctl.sv
// CSR register-file initiator: sequences CSRRD/CSRWR/CSRXCHG as a read
// phase, an optional one-cycle write phase, then returns the old value.
module cpu7_csr_ctl
  import cpu7_csr_ctl_pkg::*;
#(
  parameter int GRLEN   = 32,
  parameter int CSR_BIT = 14
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [1:0]         req_op,
  input  logic [CSR_BIT-1:0] req_csr_num,
  input  logic [GRLEN-1:0]   req_wdata,
  input  logic [GRLEN-1:0]   req_mask,
  input  logic               flush,
  output logic               resp_valid,
  input  logic               resp_ready,
  output logic [GRLEN-1:0]   resp_rdata,
  output logic [CSR_BIT-1:0] csr_raddr,
  input  logic [GRLEN-1:0]   csr_rdata,
  output logic [CSR_BIT-1:0] csr_waddr,
  output logic [GRLEN-1:0]   csr_wdata,
  output logic               csr_wen
);

  csr_st_e            state_q, state_d;
  csr_op_e            op_q, op_d;
  logic [CSR_BIT-1:0] num_q, num_d;
  logic [GRLEN-1:0]   wdata_q, wdata_d;
  logic [GRLEN-1:0]   mask_q, mask_d;
  logic [GRLEN-1:0]   old_q, old_d;
  logic [GRLEN-1:0]   wout_q, wout_d;
  logic [GRLEN-1:0]   merged;
  logic [GRLEN-1:0]   wr_val;

  cpu7_csr_xchg_merge #(.GRLEN(GRLEN)) u_merge (
    .old_val (old_q),
    .new_val (wdata_q),
    .mask    (mask_q),
    .merged  (merged)
  );

  assign wr_val = (op_q == CSR_OP_XCHG) ? merged : wdata_q;

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    num_d   = num_q;
    wdata_d = wdata_q;
    mask_d  = mask_q;
    old_d   = old_q;
    wout_d  = wout_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid && !flush) begin
          op_d    = norm_op(req_op);
          num_d   = req_csr_num;
          wdata_d = req_wdata;
          mask_d  = req_mask;
          state_d = ST_RD;
        end
      end
      ST_RD: begin
        if (flush) begin
          state_d = ST_IDLE;
        end else begin
          old_d   = csr_rdata;
          state_d = (op_q == CSR_OP_RD) ? ST_RESP : ST_WR;
        end
      end
      // The write is committed here, so flush has no effect in this state.
      ST_WR: begin
        wout_d  = wr_val;
        state_d = ST_RESP;
      end
      ST_RESP: begin
        if (flush || resp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= ST_IDLE;
      op_q    <= CSR_OP_RD;
      num_q   <= '0;
      wdata_q <= '0;
      mask_q  <= '0;
      old_q   <= '0;
      wout_q  <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      num_q   <= num_d;
      wdata_q <= wdata_d;
      mask_q  <= mask_d;
      old_q   <= old_d;
      wout_q  <= wout_d;
    end
  end

  // Write enable decodes straight from state so reset kills it asynchronously.
  assign req_ready  = (state_q == ST_IDLE);
  assign resp_valid = (state_q == ST_RESP);
  assign resp_rdata = old_q;
  assign csr_raddr  = num_q;
  assign csr_waddr  = num_q;
  assign csr_wen    = (state_q == ST_WR);
  assign csr_wdata  = csr_wen ? wr_val : wout_q;

endmodule

// File: tb/tb_cpu7_csr_ctl.sv
// Randomized bench for cpu7_csr_ctl against a transaction-level CSR file model.
module tb_cpu7_csr_ctl;

  logic        clk = 1'b0;
  logic        resetn;
  logic        req_valid, req_ready;
  logic [1:0]  req_op;
  logic [13:0] req_csr_num;
  logic [31:0] req_wdata, req_mask;
  logic        flush;
  logic        resp_valid, resp_ready;
  logic [31:0] resp_rdata;
  logic [13:0] csr_raddr, csr_waddr;
  logic [31:0] csr_rdata, csr_wdata;
  logic        csr_wen;

  bit [31:0] env_rf [0:16383];
  bit [31:0] ref_rf [0:16383];
  int        wen_cnt = 0;
  int        exp_wen = 0;
  int        n_chk = 0;
  int        n_err = 0;
  logic [31:0] last_wd = '0;
  logic [13:0] last_num = '0;

  always #5 clk = ~clk;

  cpu7_csr_ctl #(.GRLEN(32), .CSR_BIT(14)) dut (
    .clk(clk), .resetn(resetn),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_csr_num(req_csr_num), .req_wdata(req_wdata), .req_mask(req_mask),
    .flush(flush),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
    .csr_raddr(csr_raddr), .csr_rdata(csr_rdata),
    .csr_waddr(csr_waddr), .csr_wdata(csr_wdata), .csr_wen(csr_wen)
  );

  // Register file environment: combinational read, write at the clock edge.
  assign csr_rdata = env_rf[csr_raddr];
  always @(posedge clk) begin
    if (csr_wen) begin
      env_rf[csr_waddr] <= csr_wdata;
      wen_cnt <= wen_cnt + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // fl: 0 none, 1 flush in RD, 2 flush in WR, 3 flush in RESP, 4 reset in WR
  task automatic txn(input logic [1:0] op, input logic [13:0] num, input logic [31:0] wd,
                     input logic [31:0] mk, input int dly, input int fl);
    logic        is_wr;
    logic [31:0] old, nv;
    is_wr = (op == 2'b01) || (op == 2'b10);
    old   = ref_rf[num];
    nv    = (op == 2'b01) ? wd : ((wd & mk) | (old & ~mk));
    chk("idle_ready", req_ready, 1);
    req_valid = 1'b1; req_op = op; req_csr_num = num; req_wdata = wd; req_mask = mk;
    @(posedge clk); @(negedge clk);
    last_num  = num;
    req_valid = 1'b0; req_op = 2'($urandom); req_csr_num = 14'($urandom);
    req_wdata = $urandom; req_mask = $urandom;
    chk("rd_ready", req_ready, 0);
    chk("rd_raddr", csr_raddr, num);
    chk("rd_wen", csr_wen, 0);
    chk("rd_rvalid", resp_valid, 0);
    if (fl == 1) begin
      flush = 1'b1;
      @(posedge clk); @(negedge clk);
      flush = 1'b0;
      chk("flrd_ready", req_ready, 1);
      chk("flrd_rvalid", resp_valid, 0);
      chk("flrd_wen", csr_wen, 0);
      return;
    end
    @(posedge clk); @(negedge clk);
    if (is_wr) begin
      chk("wr_wen", csr_wen, 1);
      chk("wr_waddr", csr_waddr, num);
      chk("wr_wdata", csr_wdata, nv);
      chk("wr_rvalid", resp_valid, 0);
      if (fl == 4) begin
        resetn = 1'b0;
        #1;
        chk("rst_wen", csr_wen, 0);
        chk("rst_ready", req_ready, 1);
        chk("rst_rvalid", resp_valid, 0);
        chk("rst_wdata", csr_wdata, 0);
        chk("rst_raddr", csr_raddr, 0);
        chk("rst_waddr", csr_waddr, 0);
        chk("rst_rdata", resp_rdata, 0);
        last_wd = '0; last_num = '0;
        @(negedge clk);
        resetn = 1'b1;
        return;
      end
      ref_rf[num] = nv; last_wd = nv; exp_wen++;
      if (fl == 2) flush = 1'b1;
      @(posedge clk); @(negedge clk);
      flush = 1'b0;
    end else begin
      chk("rdop_nowen", csr_wen, 0);
    end
    chk("resp_valid", resp_valid, 1);
    chk("resp_rdata", resp_rdata, old);
    chk("resp_ready_lo", req_ready, 0);
    chk("resp_raddr", csr_raddr, num);
    chk("resp_wdata_hold", csr_wdata, last_wd);
    if (fl == 3) begin
      flush = 1'b1;
      @(posedge clk); @(negedge clk);
      flush = 1'b0;
      chk("flresp_rvalid", resp_valid, 0);
      chk("flresp_ready", req_ready, 1);
      return;
    end
    for (int i = 0; i < dly; i++) begin
      req_valid = 1'b1;
      @(posedge clk); @(negedge clk);
      chk("hold_rvalid", resp_valid, 1);
      chk("hold_rdata", resp_rdata, old);
      chk("hold_ready", req_ready, 0);
      chk("hold_raddr", csr_raddr, num);
    end
    req_valid  = 1'b0;
    resp_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    resp_ready = 1'b0;
    chk("done_rvalid", resp_valid, 0);
    chk("done_ready", req_ready, 1);
    chk("done_wdata", csr_wdata, last_wd);
  endtask

  task automatic flush_at_idle(input logic [13:0] num);
    req_valid = 1'b1; req_op = 2'b01; req_csr_num = num; req_wdata = $urandom; req_mask = '0;
    flush = 1'b1;
    @(posedge clk); @(negedge clk);
    req_valid = 1'b0; flush = 1'b0;
    chk("idlefl_ready", req_ready, 1);
    chk("idlefl_rvalid", resp_valid, 0);
    chk("idlefl_raddr", csr_raddr, last_num);
  endtask

  initial begin
    logic [13:0] addrs [4];
    addrs[0] = 14'h0; addrs[1] = 14'h6; addrs[2] = 14'hC; addrs[3] = 14'h1F;
    resetn = 1'b0; req_valid = 1'b0; req_op = '0; req_csr_num = '0;
    req_wdata = '0; req_mask = '0; flush = 1'b0; resp_ready = 1'b0;
    #1;
    chk("reset_ready", req_ready, 1);
    chk("reset_rvalid", resp_valid, 0);
    chk("reset_wen", csr_wen, 0);
    chk("reset_rdata", resp_rdata, 0);
    chk("reset_raddr", csr_raddr, 0);
    chk("reset_wdata", csr_wdata, 0);
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);

    txn(2'b00, 14'hC, 32'h0, 32'h0, 0, 0);
    txn(2'b01, 14'hC, 32'h1C00_0000, 32'h0, 0, 0);
    txn(2'b00, 14'hC, 32'h0, 32'h0, 0, 0);
    txn(2'b01, 14'h0, 32'h3, 32'h0, 0, 0);
    txn(2'b10, 14'h0, 32'h4, 32'h6, 0, 0);
    chk("xchg_crmd", ref_rf[0], 32'h5);
    txn(2'b00, 14'h0, 32'h0, 32'h0, 0, 0);
    txn(2'b01, 14'h6, 32'hDEAD_BEEF, 32'h0, 0, 1);
    txn(2'b01, 14'h6, 32'h1234_5678, 32'h0, 0, 2);
    txn(2'b00, 14'h6, 32'h0, 32'h0, 5, 0);
    txn(2'b11, 14'hC, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, 0);
    txn(2'b10, 14'h6, 32'hA5A5_A5A5, 32'h0F0F_0F0F, 0, 3);
    txn(2'b01, 14'hC, 32'h7777_7777, 32'h0, 0, 4);
    txn(2'b00, 14'hC, 32'h0, 32'h0, 0, 0);
    flush_at_idle(14'h6);

    for (int n = 0; n < 200; n++) begin
      logic [1:0]  op;
      logic [13:0] a;
      int          fl, r;
      op = 2'($urandom_range(0, 3));
      a  = addrs[$urandom_range(0, 3)];
      r  = $urandom_range(0, 19);
      fl = (r < 14) ? 0 : (r < 16) ? 1 : (r < 17) ? 2 : (r < 19) ? 3 : 4;
      if ((op == 2'b00 || op == 2'b11) && (fl == 2 || fl == 4)) fl = 0;
      if (r == 0) flush_at_idle(a);
      txn(op, a, $urandom, $urandom, $urandom_range(0, 3), fl);
    end

    @(negedge clk);
    chk("wen_count", wen_cnt, exp_wen);
    for (int i = 0; i < 4; i++) chk("rf_final", env_rf[addrs[i]], ref_rf[addrs[i]]);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end

endmodule
